// File: rtl/test_frame_collector_pkg.sv
// Shared types and constants for the serial frame collector.
package test_frame_collector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int FRAME_BITS          = 7;
  localparam int DEFAULT_TIMEOUT_CYC = 16;

endpackage

// File: rtl/test_gap_timer.sv
// Gap timer: flags the TIMEOUT_CYC-th consecutive running cycle without a clear.
module test_gap_timer
  import test_frame_collector_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expire
);

  logic [7:0] r_gap;
  logic       w_expire;

  // r_gap holds the number of non-clearing run cycles already elapsed,
  // so the terminal compare against TIMEOUT_CYC-1 fires on the last one.
  assign w_expire = run && !clear && (r_gap == 8'(TIMEOUT_CYC - 1));
  assign expire   = w_expire;

  // Count stalled run cycles; restart on clear, when not running, or on expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap <= 8'd0;
    end else if (clear || !run || w_expire) begin
      r_gap <= 8'd0;
    end else begin
      r_gap <= r_gap + 8'd1;
    end
  end

endmodule

// File: rtl/test_frame_collector.sv
// Serial-to-7-bit frame collector feeding the downstream decode stage.
//
//   state | meaning
//   IDLE  | no partial frame, waiting for the first bit
//   SHIFT | collecting bits 2..7, gap timer running
//   HOLD  | completed frame presented, waiting for out_ready
module test_frame_collector
  import test_frame_collector_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             ina,
  output logic             inb,
  output logic             inc,
  output logic             ind,
  output logic             ine,
  output logic             inf,
  output logic             ing,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             timeout_err
);

  state_t             r_state;
  logic [2:0]         r_bit_idx;
  logic [5:0]         r_shift;
  logic [6:0]         r_frame;
  logic               r_out_valid;
  logic [CNT_W-1:0]   r_frame_cnt;
  logic               r_timeout_err;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_run;
  logic               w_clear;
  logic               w_expire;

  assign w_in_ready = (r_state != HOLD);
  assign w_accept   = in_valid && w_in_ready;
  assign w_run      = (r_state == SHIFT);
  assign w_clear    = w_accept || abort;

  test_gap_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_gap_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (w_run),
    .clear (w_clear),
    .expire(w_expire)
  );

  // Frame FSM, shift register, held frame and handshake counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_bit_idx     <= 3'd0;
      r_shift       <= 6'd0;
      r_frame       <= 7'd0;
      r_out_valid   <= 1'b0;
      r_frame_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      if (abort) begin
        // Drops any partial or held frame; the presented frame bits stay put.
        r_state     <= IDLE;
        r_bit_idx   <= 3'd0;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_shift[0] <= in_bit;
              r_bit_idx  <= 3'd1;
              r_state    <= SHIFT;
            end
          end
          SHIFT: begin
            if (w_accept) begin
              if (r_bit_idx == 3'(FRAME_BITS - 1)) begin
                // r_frame[0] is ina, r_frame[6] is ing.
                r_frame     <= {in_bit, r_shift};
                r_out_valid <= 1'b1;
                r_bit_idx   <= 3'd0;
                r_state     <= HOLD;
              end else begin
                for (int i = 0; i < FRAME_BITS - 1; i++) begin
                  if (r_bit_idx == 3'(i)) begin
                    r_shift[i] <= in_bit;
                  end
                end
                r_bit_idx <= r_bit_idx + 3'd1;
              end
            end else if (w_expire) begin
              r_bit_idx     <= 3'd0;
              r_state       <= IDLE;
              r_timeout_err <= 1'b1;
            end
          end
          HOLD: begin
            if (out_ready) begin
              r_out_valid <= 1'b0;
              r_frame_cnt <= r_frame_cnt + CNT_W'(1);
              r_state     <= IDLE;
            end
          end
          default: begin
            r_state   <= IDLE;
            r_bit_idx <= 3'd0;
          end
        endcase
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign frame_cnt   = r_frame_cnt;
  assign timeout_err = r_timeout_err;
  assign ina         = r_frame[0];
  assign inb         = r_frame[1];
  assign inc         = r_frame[2];
  assign ind         = r_frame[3];
  assign ine         = r_frame[4];
  assign inf         = r_frame[5];
  assign ing         = r_frame[6];

endmodule

// File: tb/tb_test_frame_collector.sv
// Scoreboard bench for test_frame_collector: a driver steps a bit-level
// reference model and queues expected events; a monitor checks them.
module tb_test_frame_collector;

  localparam int TO    = 16;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_bit = 1'b0, in_valid = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, timeout_err;
  logic ina, inb, inc, ind, ine, inf, ing;
  logic [CNT_W-1:0] frame_cnt;

  always #5 clk = ~clk;

  test_frame_collector #(.TIMEOUT_CYC(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort),
    .ina(ina), .inb(inb), .inc(inc), .ind(ind), .ine(ine), .inf(inf), .ing(ing),
    .out_valid(out_valid), .out_ready(out_ready), .frame_cnt(frame_cnt),
    .timeout_err(timeout_err)
  );

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t frame_q[$];
  ev_t cnt_q[$];
  ev_t to_q[$];

  int n_tot = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int frame_now();
    return int'({ina, inb, inc, ind, ine, inf, ing});
  endfunction

  // Reference model: a frame is simply the list of bits accepted so far.
  logic m_held;
  int   m_bits[$];
  int   m_gap;
  int   m_cnt;

  task automatic model_reset();
    m_held = 1'b0;
    m_bits.delete();
    m_gap = 0;
    m_cnt = 0;
  endtask

  task automatic step(input logic v, input logic b, input logic ab, input logic ordy);
    int f;
    chk("in_ready", int'(in_ready), int'(!m_held));
    chk("out_valid", int'(out_valid), int'(m_held));
    in_valid = v; in_bit = b; abort = ab; out_ready = ordy;
    if (ab) begin
      m_held = 1'b0;
      m_bits.delete();
      m_gap = 0;
    end else if (m_held) begin
      if (ordy) begin
        m_held = 1'b0;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        cnt_q.push_back('{cyc + 1, m_cnt});
      end
    end else if (v) begin
      m_bits.push_back(int'(b));
      m_gap = 0;
      if (m_bits.size() == 7) begin
        f = 0;
        foreach (m_bits[i]) f = f * 2 + m_bits[i];
        frame_q.push_back('{cyc + 1, f});
        m_held = 1'b1;
        m_bits.delete();
      end
    end else if (m_bits.size() > 0) begin
      m_gap++;
      if (m_gap == TO) begin
        to_q.push_back('{cyc + 1, 1});
        m_bits.delete();
        m_gap = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bit(input logic b);
    step(1'b1, b, 1'b0, 1'b0);
  endtask

  // Bits go out ina first, i.e. MSB of the 7-bit literal first.
  task automatic send_frame(input logic [6:0] f);
    for (int i = 6; i >= 0; i--) send_bit(f[i]);
  endtask

  task automatic handshake();
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: pops expected events whenever the DUT presents one.
  initial begin
    int p_valid, p_frame, p_cnt, w;
    ev_t e;
    p_valid = 0; p_frame = 0; p_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_valid = 0; p_frame = 0; p_cnt = 0;
      end else begin
        w = frame_now();
        if (out_valid && p_valid == 0) begin
          if (frame_q.size() == 0) chk("frame_unexpected", 1, 0);
          else begin
            e = frame_q.pop_front();
            chk("frame_val", w, e.val);
            chk("frame_cyc", cyc, e.cyc);
          end
        end else begin
          chk("frame_stable", w, p_frame);
        end
        if (int'(frame_cnt) != p_cnt) begin
          if (cnt_q.size() == 0) chk("cnt_unexpected", int'(frame_cnt), p_cnt);
          else begin
            e = cnt_q.pop_front();
            chk("cnt_val", int'(frame_cnt), e.val);
            chk("cnt_cyc", cyc, e.cyc);
          end
        end
        if (timeout_err) begin
          if (to_q.size() == 0) chk("timeout_unexpected", 1, 0);
          else begin
            e = to_q.pop_front();
            chk("timeout_cyc", cyc, e.cyc);
          end
        end
        p_valid = int'(out_valid); p_frame = w; p_cnt = int'(frame_cnt);
      end
    end
  end

  initial begin
    int saved_cnt, saved_frame, r, n;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_frame", frame_now(), 0);
    chk("rst_cnt", int'(frame_cnt), 0);
    chk("rst_timeout", int'(timeout_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Plan 1: first frame, held under back-pressure.
    send_frame(7'b0000110);
    chk("t1_frame", frame_now(), 7'b0000110);
    chk("t1_in_ready", int'(in_ready), 0);
    idle(10);
    chk("t1_frame_hold", frame_now(), 7'b0000110);
    chk("t1_cnt", int'(frame_cnt), 0);

    // Plan 2: handshake and a second frame.
    handshake();
    chk("t2_cnt1", int'(frame_cnt), 1);
    chk("t2_in_ready", int'(in_ready), 1);
    send_frame(7'b1010101);
    handshake();
    chk("t2_frame", frame_now(), 7'b1010101);
    chk("t2_cnt2", int'(frame_cnt), 2);

    // Plan 3: timeout after 16 idle cycles in SHIFT.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    idle(15);
    chk("t3_no_early_timeout", int'(timeout_err), 0);
    idle(1);
    chk("t3_timeout_pulse", int'(timeout_err), 1);
    idle(1);
    chk("t3_timeout_width", int'(timeout_err), 0);
    send_frame(7'b1111111);
    chk("t3_frame", frame_now(), 7'b1111111);
    handshake();

    // Plan 4: accept on the expiring cycle wins.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    idle(15);
    send_bit(1'b0);
    chk("t4_no_timeout", int'(timeout_err), 0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("t4_frame", frame_now(), 7'b1100101);
    chk("t4_valid", int'(out_valid), 1);
    handshake();

    // Plan 5: abort in HOLD with out_ready, then abort mid-SHIFT.
    send_frame(7'b0011001);
    saved_cnt = int'(frame_cnt);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5_abort_valid", int'(out_valid), 0);
    chk("t5_abort_cnt", int'(frame_cnt), saved_cnt);
    chk("t5_abort_frame", frame_now(), 7'b0011001);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(7'b0110011);
    chk("t5_new_frame", frame_now(), 7'b0110011);
    handshake();

    // Plan 6: asynchronous reset mid-frame.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_frame", frame_now(), 0);
    chk("t6_async_cnt", int'(frame_cnt), 0);
    chk("t6_async_valid", int'(out_valid), 0);
    chk("t6_async_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // Plan 6: frame counter wrap.
    for (int i = 0; i < 256; i++) begin
      send_frame(7'($urandom));
      handshake();
      if (i == 254) chk("t6_cnt_255", int'(frame_cnt), 255);
    end
    chk("t6_cnt_wrap", int'(frame_cnt), 0);

    // Randomized traffic with occasional stalls and aborts.
    n = 0;
    while (n < 2500) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        idle(int'($urandom_range(10, 20)));
        n += 20;
      end else if (r < 5) begin
        step(1'b0, 1'b0, 1'b1, 1'($urandom));
        n++;
      end else begin
        step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'b0,
             1'($urandom_range(0, 2) == 0));
        n++;
      end
    end
    idle(2);
    @(negedge clk);
    chk("end_frame_q_empty", frame_q.size(), 0);
    chk("end_cnt_q_empty", cnt_q.size(), 0);
    chk("end_timeout_q_empty", to_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
